irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Memory-mapped interrupt controller feeding the pipelined core's interrupt input (`irq`, the signal the on-chip logic analyzer uses as its trigger). It captures rising edges on peripheral interrupt lines into a pending register, masks them with an enable register, and selects the lowest-numbered active source. It presents a single registered request to the core and runs a request/acknowledge/end-of-interrupt handshake so only one interrupt is in service at a time.

## Interface
- `N_SRC`, default 4: number of interrupt source lines, 1..16.
- `DW`, default 32: data bus width.
- `clk`, in, 1: system clock; all logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `src_i`, in, `N_SRC`: peripheral interrupt lines, already synchronous to `clk`, level form; the controller detects rising edges.
- `we`, in, 1: bus write strobe, one cycle per write.
- `re`, in, 1: bus read strobe, one cycle per read.
- `addr`, in, 4: byte address; only `addr[3:2]` is decoded.
- `wdata`, in, `DW`: write data.
- `rdata`, out, `DW`: read data, registered.
- `irq`, out, 1: interrupt request to the core, registered.
- `irq_id`, out, 4: index of the requesting or in-service source, registered.
- `irq_ack`, in, 1: one-cycle pulse from the core when it takes the trap.

## Operation
- **Edge detect:** `src_q` is `src_i` delayed one cycle. `rise = src_i & ~src_q`. `src_q` resets to 0.
- **Register map** (`addr[3:2]`):
  - 0 PENDING: read; write-1-to-clear.
  - 1 ENABLE: read/write, low `N_SRC` bits.
  - 2 CLAIM: read-only; returns `irq_id` zero-extended, bit 31 = in service.
  - 3 EOI: write any value to end service.
  - Unused upper bits read 0.
- **Pending update:** `pending <= (pending & ~w1c_mask) | rise`. A set wins over a same-cycle clear of the same bit.
- **Selection:** `active = pending & enable`. `sel` is the lowest set index of `active`, from a combinational priority encoder.
- **State machine** (state resets to IDLE):
  - IDLE: if `active != 0`, latch `irq_id <= sel`, set `irq <= 1`, go to REQ.
  - REQ: if `irq_ack`, clear `pending[irq_id]`, set `irq <= 0`, go to SERVICE. Otherwise, if `active[irq_id]` has dropped (masked or W1C-cleared), set `irq <= 0` and go to IDLE. `irq_ack` wins over a same-cycle drop.
  - SERVICE: hold `irq_id`. A write to EOI goes to IDLE. New edges keep accumulating in `pending`.
- `irq_id` does not change while in REQ, even if a higher-priority source becomes pending. Priority is re-evaluated only in IDLE.
- `irq_ack` outside REQ is ignored. An EOI write outside SERVICE is ignored.
- A bus read and write in the same cycle is legal. The read returns the pre-write value.
- **Reset values** (a mid-operation `rst` returns here in one cycle and discards all in-flight state):
  - `pending`, `enable`, `src_q`, `rdata`: 0.
  - `irq`, `irq_id`: 0.
  - state: IDLE.

## Timing
- `src_i` rises in cycle n → `pending` bit set at the edge ending n → `irq` high at the edge ending n+1 (2-cycle latency), provided the source is enabled and the state is IDLE.
- `irq_ack` in cycle m → `irq` low and `pending` bit clear after the edge ending m.
- EOI write in cycle k → IDLE after the edge ending k → if `active` is nonzero, `irq` is high again after the edge ending k+1.
- Read latency: `rdata` is valid the cycle after `re`, and holds its value when `re` is low.
- `irq` and `irq_id` always change on the same edge.

## Structure
- Shared package `irq_pkg` holds:
  - the register offset constants `IRQ_PENDING`, `IRQ_ENABLE`, `IRQ_CLAIM`, `IRQ_EOI`;
  - the state enum `irq_state_t` (IDLE, REQ, SERVICE).
- Sub-module `irq_prio_enc` is a parameterised combinational lowest-index priority encoder with a `valid` output. It is the only sub-module.

## Test plan
- Reset, then ENABLE=0xF; pulse `src_i[2]` → `irq`=1 with `irq_id`=2 two cycles later; `irq_ack` → `irq`=0, PENDING=0x0; CLAIM reads 0x80000002.
- With ENABLE=0xF, `src_i[3]` and `src_i[1]` rise in the same cycle → `irq_id`=1. After ack and EOI, `irq_id`=3 with `irq` reasserted one cycle after EOI.
- With ENABLE=0x0, pulse `src_i[0]` → PENDING=0x1 and `irq` stays 0. Write ENABLE=0x1 → `irq`=1 on the cycle after the write takes effect.
- In REQ for source 0, write PENDING=0x1 (W1C) with no ack → `irq`=0, back to IDLE. Repeat with `irq_ack` in the same cycle → SERVICE, `irq`=0.
- W1C of bit 1 in the same cycle `src_i[1]` rises → PENDING bit 1 stays 1.
- Assert `rst` while in SERVICE with PENDING=0x6 → next cycle `irq`=0, `irq_id`=0, PENDING=0, ENABLE=0. A subsequent EOI write has no effect.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets
// (addr[3:2]) and the request/service state machine encoding.
package irq_pkg;

   localparam logic [1:0] IRQ_PENDING = 2'd0;
   localparam logic [1:0] IRQ_ENABLE  = 2'd1;
   localparam logic [1:0] IRQ_CLAIM   = 2'd2;
   localparam logic [1:0] IRQ_EOI     = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index priority encoder. idx_o is the position of the
// lowest set bit of req_i; valid_o flags that any bit is set (idx_o is 0
// when none is).
module irq_prio_enc #(
   parameter int N  = 4,
   parameter int IW = 4
) (
   input  logic [N-1:0]  req_i,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      idx_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o = IW'(i);
         end
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: rising-edge capture into PENDING,
// masking by ENABLE, lowest-index selection and a req/ack/EOI handshake that
// keeps a single interrupt in service at a time.
module irq_ctrl
   import irq_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int DW    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] src_i,
   input  logic             we,
   input  logic             re,
   input  logic [3:0]       addr,
   input  logic [DW-1:0]    wdata,
   output logic [DW-1:0]    rdata,
   output logic             irq,
   output logic [3:0]       irq_id,
   input  logic             irq_ack
);

   logic [N_SRC-1:0] src_q;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] enable_q, enable_d;
   logic [DW-1:0]    rdata_q, rdata_d;
   irq_state_t       state_q, state_d;
   logic             irq_q, irq_d;
   logic [3:0]       irq_id_q, irq_id_d;

   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] active;
   logic [N_SRC-1:0] w1c_mask;
   logic [N_SRC-1:0] ack_mask;
   logic [N_SRC-1:0] id_onehot;
   logic [1:0]       reg_sel;
   logic             wr_pending, wr_enable, wr_eoi;
   logic             id_active;
   logic             ack_take;
   logic [3:0]       sel;
   logic             sel_valid;

   // Only addr[3:2] and the low N_SRC data bits carry meaning.
   logic unused_bits;
   assign unused_bits = ^{addr[1:0], wdata[DW-1:N_SRC]};

   assign reg_sel    = addr[3:2];
   assign wr_pending = we && (reg_sel == IRQ_PENDING);
   assign wr_enable  = we && (reg_sel == IRQ_ENABLE);
   assign wr_eoi     = we && (reg_sel == IRQ_EOI);

   assign rise     = src_i & ~src_q;
   assign active   = pending_q & enable_q;
   assign w1c_mask = wr_pending ? wdata[N_SRC-1:0] : '0;

   // One-hot view of the latched id, so narrow N_SRC never indexes out of range.
   generate
      for (genvar gi = 0; gi < N_SRC; gi++) begin : g_id_dec
         assign id_onehot[gi] = (irq_id_q == 4'(gi));
      end
   endgenerate

   assign id_active = |(active & id_onehot);
   assign ack_take  = (state_q == REQ) && irq_ack;
   assign ack_mask  = ack_take ? id_onehot : '0;

   irq_prio_enc #(
      .N  (N_SRC),
      .IW (4)
   ) u_prio (
      .req_i   (active),
      .idx_o   (sel),
      .valid_o (sel_valid)
   );

   // Clears (W1C and ack) apply first; a same-cycle rising edge re-sets the bit.
   always_comb begin
      pending_d = (pending_q & ~w1c_mask & ~ack_mask) | rise;
      enable_d  = wr_enable ? wdata[N_SRC-1:0] : enable_q;
   end

   // Read mux on pre-write register values; rdata holds while re is low.
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = '0;
         case (reg_sel)
            IRQ_PENDING: rdata_d = DW'(pending_q);
            IRQ_ENABLE:  rdata_d = DW'(enable_q);
            IRQ_CLAIM: begin
               rdata_d[3:0]  = irq_id_q;
               rdata_d[DW-1] = (state_q == SERVICE);
            end
            default:     rdata_d = '0;
         endcase
      end
   end

   // Handshake FSM: pick a source in IDLE, hold it through REQ and SERVICE.
   always_comb begin
      state_d  = state_q;
      irq_d    = irq_q;
      irq_id_d = irq_id_q;
      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               irq_id_d = sel;
               irq_d    = 1'b1;
               state_d  = REQ;
            end
         end
         REQ: begin
            if (irq_ack) begin
               irq_d   = 1'b0;
               state_d = SERVICE;
            end else if (!id_active) begin
               irq_d   = 1'b0;
               state_d = IDLE;
            end
         end
         SERVICE: begin
            irq_d = 1'b0;
            if (wr_eoi) begin
               state_d = IDLE;
            end
         end
         default: begin
            irq_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         src_q     <= '0;
         pending_q <= '0;
         enable_q  <= '0;
         rdata_q   <= '0;
         state_q   <= IDLE;
         irq_q     <= 1'b0;
         irq_id_q  <= '0;
      end else begin
         src_q     <= src_i;
         pending_q <= pending_d;
         enable_q  <= enable_d;
         rdata_q   <= rdata_d;
         state_q   <= state_d;
         irq_q     <= irq_d;
         irq_id_q  <= irq_id_d;
      end
   end

   assign rdata  = rdata_q;
   assign irq    = irq_q;
   assign irq_id = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios followed by random traffic, all
// compared each cycle against a behavioural model of the controller.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  src_i;
   logic        we, re, irq_ack;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;
   logic [3:0]  irq_id;

   int n_cmp = 0;
   int n_bad = 0;

   logic [3:0] src_v;

   // Behavioural model state.
   logic [3:0]  m_src, m_pend, m_en, m_id;
   logic        m_req, m_svc;
   logic [31:0] m_rd;

   irq_ctrl #(.N_SRC(4), .DW(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .src_i   (src_i),
      .we      (we),
      .re      (re),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .irq     (irq),
      .irq_id  (irq_id),
      .irq_ack (irq_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] lowest(input logic [3:0] v);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 3; i >= 0; i--) if (v[i]) r = 4'(i);
      return r;
   endfunction

   // Advance the model by one clock using the inputs applied this cycle.
   task automatic model_step(input logic [3:0] s, input logic w, input logic r,
                             input logic [3:0] a, input logic [31:0] d, input logic k);
      logic [3:0] act, rise, nxt;
      if (rst) begin
         m_src = 0; m_pend = 0; m_en = 0; m_id = 0; m_req = 0; m_svc = 0; m_rd = 0;
      end else begin
         act  = m_pend & m_en;
         rise = s & ~m_src;
         if (r) begin
            case (a[3:2])
               2'd0: m_rd = {28'd0, m_pend};
               2'd1: m_rd = {28'd0, m_en};
               2'd2: m_rd = {m_svc, 27'd0, m_id};
               default: m_rd = 32'd0;
            endcase
         end
         nxt = m_pend;
         if (w && a[3:2] == 2'd0) nxt = nxt & ~d[3:0];
         if (m_req) begin
            if (k) begin
               nxt[m_id] = 1'b0;
               m_req = 1'b0;
               m_svc = 1'b1;
            end else if (!act[m_id]) begin
               m_req = 1'b0;
            end
         end else if (m_svc) begin
            if (w && a[3:2] == 2'd3) m_svc = 1'b0;
         end else if (act != 4'd0) begin
            m_id  = lowest(act);
            m_req = 1'b1;
         end
         m_pend = nxt | rise;
         if (w && a[3:2] == 2'd1) m_en = d[3:0];
         m_src = s;
      end
   endtask

   // One transaction per clock: drive, step model, compare on the falling edge.
   task automatic cycle(input logic [3:0] s, input logic w, input logic r,
                        input logic [3:0] a, input logic [31:0] d, input logic k);
      src_i = s; we = w; re = r; addr = a; wdata = d; irq_ack = k;
      @(posedge clk);
      model_step(s, w, r, a, d, k);
      @(negedge clk);
      check("irq", {31'd0, irq}, {31'd0, m_req});
      check("irq_id", {28'd0, irq_id}, {28'd0, m_id});
      check("rdata", rdata, m_rd);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      cycle(src_v, 1'b1, 1'b0, a, d, 1'b0);
   endtask

   task automatic rd(input logic [3:0] a);
      cycle(src_v, 1'b0, 1'b1, a, 32'd0, 1'b0);
   endtask

   task automatic idle();
      cycle(src_v, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
   endtask

   task automatic ack();
      cycle(src_v, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
   endtask

   initial begin
      rst = 1'b1; src_v = 4'd0;
      src_i = 0; we = 0; re = 0; addr = 0; wdata = 0; irq_ack = 0;
      idle(); idle();
      rst = 1'b0;
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_id", {28'd0, irq_id}, 32'd0);
      check("rst_rdata", rdata, 32'd0);

      // Single source, two-cycle latency, ack, CLAIM.
      wr(4'h4, 32'hF);
      src_v = 4'b0100; idle();
      check("t1_lat1", {31'd0, irq}, 32'd0);
      idle();
      check("t1_irq", {31'd0, irq}, 32'd1);
      check("t1_id", {28'd0, irq_id}, 32'd2);
      src_v = 4'd0; ack();
      check("t1_ack", {31'd0, irq}, 32'd0);
      rd(4'h0);
      check("t1_pend", rdata, 32'd0);
      rd(4'h8);
      check("t1_claim", rdata, 32'h8000_0002);
      wr(4'hC, 32'd0);

      // Simultaneous edges: lowest first, then the other after EOI.
      src_v = 4'b1010; idle(); idle();
      check("t2_id1", {28'd0, irq_id}, 32'd1);
      src_v = 4'd0; ack();
      wr(4'hC, 32'd0);
      check("t2_eoi0", {31'd0, irq}, 32'd0);
      idle();
      check("t2_irq", {31'd0, irq}, 32'd1);
      check("t2_id3", {28'd0, irq_id}, 32'd3);
      ack(); wr(4'hC, 32'd0); idle();

      // Masked source stays pending until enabled.
      wr(4'h4, 32'h0);
      src_v = 4'b0001; idle();
      src_v = 4'd0; idle();
      check("t3_masked", {31'd0, irq}, 32'd0);
      rd(4'h0);
      check("t3_pend", rdata, 32'd1);
      wr(4'h4, 32'h1);
      check("t3_wr", {31'd0, irq}, 32'd0);
      idle();
      check("t3_irq", {31'd0, irq}, 32'd1);

      // W1C while requesting drops back to IDLE; with ack it goes to SERVICE.
      wr(4'h0, 32'h1);
      idle();
      check("t4_drop", {31'd0, irq}, 32'd0);
      src_v = 4'b0001; idle();
      src_v = 4'd0; idle();
      check("t4_req", {31'd0, irq}, 32'd1);
      cycle(src_v, 1'b1, 1'b0, 4'h0, 32'h1, 1'b1);
      check("t4_ackw", {31'd0, irq}, 32'd0);
      rd(4'h8);
      check("t4_claim", rdata, 32'h8000_0000);
      wr(4'hC, 32'd0);

      // A rising edge beats a same-cycle W1C of the same bit.
      wr(4'h4, 32'h0);
      src_v = 4'b0010;
      cycle(src_v, 1'b1, 1'b0, 4'h0, 32'h2, 1'b0);
      src_v = 4'd0; rd(4'h0);
      check("t5_setwins", rdata, 32'd2);
      wr(4'h0, 32'h2);

      // Reset in SERVICE with PENDING=0x6.
      wr(4'h4, 32'hF);
      src_v = 4'b0110; idle(); idle();
      check("t6_id", {28'd0, irq_id}, 32'd1);
      src_v = 4'd0; ack();
      src_v = 4'b0010; idle();
      src_v = 4'd0; rd(4'h0);
      check("t6_pend", rdata, 32'd6);
      rst = 1'b1; idle(); rst = 1'b0;
      check("t6_irq", {31'd0, irq}, 32'd0);
      check("t6_id0", {28'd0, irq_id}, 32'd0);
      rd(4'h0);
      check("t6_pend0", rdata, 32'd0);
      rd(4'h4);
      check("t6_en0", rdata, 32'd0);
      wr(4'hC, 32'd0); idle();
      check("t6_eoi", {31'd0, irq}, 32'd0);
      rd(4'h8);
      check("t6_claim", rdata, 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(199) == 0);
         cycle(4'($urandom), ($urandom_range(3) == 0), 1'($urandom),
               4'($urandom), $urandom, ($urandom_range(2) == 0));
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
